hazard_detection_unit: RTL

//  Producer-side counterpart of the forwarding logic: tracks in-flight destination registers of the EXE/MEM/WB stages.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hazard_detection_unit_if.sv | 36 +++
 rtl/hazard_track_pipe.sv | 37 +++
 rtl/hazard_detection_unit.sv | 108 ++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard detection unit.
//   REG_W         : register-id width (16 architectural registers)
//   track_entry_t : one in-flight producer slot {valid, wb_en, mem_r, dest}
//   stage_e       : index of a tracker slot (EXE, MEM, WB)
//   entry_match   : true when a slot holds a live write to register s
package hazard_pkg;

  localparam int REG_W      = 4;
  localparam int NUM_REGS   = 1 << REG_W;
  localparam int NUM_STAGES = 3;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r;
    logic [REG_W-1:0] dest;
  } track_entry_t;

  typedef enum logic [1:0] {
    EXE = 2'd0,
    MEM = 2'd1,
    WB  = 2'd2
  } stage_e;

  function automatic logic entry_match(input track_entry_t e, input logic [REG_W-1:0] s);
    return e.valid & e.wb_en & (e.dest == s);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Control/status bundle between the decode stage and the hazard unit.
//   master : decode side, drives mode/pipeline controls and the ID instruction fields
//   slave  : hazard unit, returns hazard_stall, pending_mask, stall_count, watchdog_err
interface hazard_detection_unit_if #(
  parameter int CNT_W = 32
);
  import hazard_pkg::*;

  logic                forwarding_mode;
  logic                freeze;
  logic                flush;
  logic                id_valid;
  logic [REG_W-1:0]    id_src1;
  logic [REG_W-1:0]    id_src2;
  logic                id_two_src;
  logic                id_wb_en;
  logic [REG_W-1:0]    id_dest;
  logic                id_mem_r_en;
  logic                hazard_stall;
  logic [NUM_REGS-1:0] pending_mask;
  logic [CNT_W-1:0]    stall_count;
  logic                watchdog_err;

  modport master (
    output forwarding_mode, freeze, flush, id_valid, id_src1, id_src2,
           id_two_src, id_wb_en, id_dest, id_mem_r_en,
    input  hazard_stall, pending_mask, stall_count, watchdog_err
  );

  modport slave (
    input  forwarding_mode, freeze, flush, id_valid, id_src1, id_src2,
           id_two_src, id_wb_en, id_dest, id_mem_r_en,
    output hazard_stall, pending_mask, stall_count, watchdog_err
  );

endinterface

// File: rtl/hazard_track_pipe.sv
// Three-slot shadow of the EXE/MEM/WB producers.
//   clk, rst      : clock, async active-high reset (all slots invalid)
//   freeze        : hold every slot
//   insert_bubble : load an invalid slot into EXE instead of id_entry
//   id_entry      : the instruction leaving ID
//   entries       : all three slots, indexed by stage_e
module hazard_track_pipe
  import hazard_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze,
  input  logic                           insert_bubble,
  input  track_entry_t                   id_entry,
  output track_entry_t [NUM_STAGES-1:0]  entries
);

  track_entry_t [NUM_STAGES-1:0] entries_q;
  track_entry_t [NUM_STAGES-1:0] entries_d;

  always_comb begin
    entries_d = entries_q;
    if (!freeze) begin
      entries_d[WB]  = entries_q[MEM];
      entries_d[MEM] = entries_q[EXE];
      entries_d[EXE] = insert_bubble ? '0 : id_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) entries_q <= '0;
    else     entries_q <= entries_d;
  end

  assign entries = entries_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: compares the ID operands against in-flight producers
// and stalls decode when a value cannot be bypassed.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of hazard_detection_unit_if (ID fields in, stall/status out)
// Parameters: RF_BYPASS (WB producer readable by ID without stall),
//             CNT_W (stall counter width), WDOG_MAX (allowed consecutive stalls).
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 32,
  parameter int WDOG_MAX  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  hazard_detection_unit_if.slave  bus
);

  localparam int CONSEC_W = $clog2(WDOG_MAX + 1);

  track_entry_t [NUM_STAGES-1:0] entries;
  track_entry_t                  id_entry;
  logic                          hazard_stall;
  logic                          stall_evt;
  logic [NUM_REGS-1:0]           pending_mask;

  logic [CNT_W-1:0]    stall_count_q, stall_count_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic                watchdog_err_q, watchdog_err_d;

  // With forwarding only a load still in EXE is unreachable; without it every
  // producer blocks until it is visible through the register file.
  function automatic logic src_blocks(input logic [REG_W-1:0] src, input logic fwd,
                                      input track_entry_t exe, input track_entry_t mem,
                                      input track_entry_t wb);
    logic hit;
    if (fwd) hit = entry_match(exe, src) & exe.mem_r;
    else     hit = entry_match(exe, src) | entry_match(mem, src) |
                   (!RF_BYPASS & entry_match(wb, src));
    return hit;
  endfunction

  assign id_entry = '{valid: bus.id_valid, wb_en: bus.id_wb_en,
                      mem_r: bus.id_mem_r_en, dest: bus.id_dest};

  always_comb begin
    hazard_stall = 1'b0;
    if (bus.id_valid) begin
      hazard_stall = src_blocks(bus.id_src1, bus.forwarding_mode,
                                entries[EXE], entries[MEM], entries[WB]) |
                     (bus.id_two_src & src_blocks(bus.id_src2, bus.forwarding_mode,
                                entries[EXE], entries[MEM], entries[WB]));
    end
  end

  // A flushed stall is squashed along with the instruction, so it is not counted.
  assign stall_evt = hazard_stall & !bus.freeze & !bus.flush;

  always_comb begin
    pending_mask = '0;
    if (entries[EXE].valid & entries[EXE].wb_en) pending_mask[entries[EXE].dest] = 1'b1;
    if (entries[MEM].valid & entries[MEM].wb_en) pending_mask[entries[MEM].dest] = 1'b1;
    if (entries[WB].valid  & entries[WB].wb_en)  pending_mask[entries[WB].dest]  = 1'b1;
  end

  hazard_track_pipe u_track (
    .clk           (clk),
    .rst           (rst),
    .freeze        (bus.freeze),
    .insert_bubble (hazard_stall | bus.flush),
    .id_entry      (id_entry),
    .entries       (entries)
  );

  always_comb begin
    stall_count_d  = stall_count_q;
    consec_d       = consec_q;
    watchdog_err_d = watchdog_err_q;
    if (!bus.freeze) begin
      if (stall_evt) begin
        if (stall_count_q != '1) stall_count_d = stall_count_q + 1'b1;
        // consec saturates at WDOG_MAX; one more stall beyond that trips the watchdog
        if (consec_q >= CONSEC_W'(WDOG_MAX)) watchdog_err_d = 1'b1;
        else                                 consec_d = consec_q + 1'b1;
      end else begin
        consec_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q  <= '0;
      consec_q       <= '0;
      watchdog_err_q <= 1'b0;
    end else begin
      stall_count_q  <= stall_count_d;
      consec_q       <= consec_d;
      watchdog_err_q <= watchdog_err_d;
    end
  end

  assign bus.hazard_stall = hazard_stall;
  assign bus.pending_mask = pending_mask;
  assign bus.stall_count  = stall_count_q;
  assign bus.watchdog_err = watchdog_err_q;

endmodule
